// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emulator
//  Purpose  : Responder end of a 4x4 column-scan / row-sense keypad matrix.
//             Accepts "press key K for N cycles" commands over valid/ready
//             and closes the addressed contact so rows answer column strobes
//             combinationally, like a physical keypad.
//  Options  : define KEYPAD_EMU_BOUNCE_EN to add contact-bounce bursts
//             before and after each hold.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
   parameter int HOLD_W        = 8,
   parameter int GAP_CYCLES    = 4,
   parameter int BOUNCE_CYCLES = 6
) (
   input  logic              scan_clk,
   input  logic              rst_n,
   input  logic              col_1,
   input  logic              col_2,
   input  logic              col_3,
   input  logic              col_4,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_key,
   input  logic [HOLD_W-1:0] cmd_hold,
   output logic              row_1,
   output logic              row_2,
   output logic              row_3,
   output logic              row_4,
   output logic              busy,
   output logic              done
);

   // One counter serves every timed state, so it must fit the widest load.
   localparam int c_GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam int c_BNC_W  = $clog2(BOUNCE_CYCLES + 1);
   localparam int c_MAX_GB = (c_GAP_W > c_BNC_W) ? c_GAP_W : c_BNC_W;
   localparam int c_CNT_W  = (HOLD_W > c_MAX_GB) ? HOLD_W : c_MAX_GB;

   localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_GAP = c_CNT_W'(GAP_CYCLES);
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam logic [c_CNT_W-1:0] c_BNC = c_CNT_W'(BOUNCE_CYCLES);
`endif

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_PRESS_BOUNCE   = 3'd1,
      ST_RELEASE_BOUNCE = 3'd3,
`endif
      ST_HOLD           = 3'd2,
      ST_GAP            = 3'd4
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [3:0]           r_key;
   logic                 r_closed;
`ifdef KEYPAD_EMU_BOUNCE_EN
   logic [c_CNT_W-1:0]   r_hold;   // hold length parked during the press burst
`endif

   logic [c_CNT_W-1:0]   w_hold_eff;
   logic [3:0]           w_cols;
   logic                 w_col_sel;
   logic [3:0]           w_rows;

   // A zero hold still closes the contact for one cycle.
   assign w_hold_eff = (cmd_hold == '0) ? c_ONE : c_CNT_W'(cmd_hold);

   // Command sequencer: every timed state loads r_cnt on entry and leaves at 1.
   always_ff @(posedge scan_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_key     <= '0;
         r_closed  <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
         r_hold    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_key     <= cmd_key;
                  r_closed  <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                  r_hold    <= w_hold_eff;
                  r_cnt     <= c_BNC;
                  r_state   <= ST_PRESS_BOUNCE;
`else
                  r_cnt     <= w_hold_eff;
                  r_state   <= ST_HOLD;
`endif
               end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            // Burst starts closed and toggles every cycle; settles closed.
            ST_PRESS_BOUNCE: begin
               if (r_cnt == c_ONE) begin
                  r_cnt    <= r_hold;
                  r_closed <= 1'b1;
                  r_state  <= ST_HOLD;
               end else begin
                  r_cnt    <= r_cnt - c_ONE;
                  r_closed <= ~r_closed;
               end
            end
`endif
            ST_HOLD: begin
               if (r_cnt == c_ONE) begin
                  r_closed <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                  r_cnt    <= c_BNC;
                  r_state  <= ST_RELEASE_BOUNCE;
`else
                  r_cnt    <= c_GAP;
                  r_state  <= ST_GAP;
`endif
               end else begin
                  r_cnt <= r_cnt - c_ONE;
               end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            // Burst starts open and toggles every cycle; settles open.
            ST_RELEASE_BOUNCE: begin
               if (r_cnt == c_ONE) begin
                  r_cnt    <= c_GAP;
                  r_closed <= 1'b0;
                  r_state  <= ST_GAP;
               end else begin
                  r_cnt    <= r_cnt - c_ONE;
                  r_closed <= ~r_closed;
               end
            end
`endif
            ST_GAP: begin
               if (r_cnt == c_ONE) begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - c_ONE;
               end
            end
            default: begin
               r_closed  <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_cols    = {col_4, col_3, col_2, col_1};
   assign w_col_sel = w_cols[r_key[1:0]];

   // Zero-latency row response: only the addressed row follows its own column.
   always_comb begin
      w_rows = 4'hF;
      if (r_closed && !w_col_sel) begin
         w_rows[r_key[3:2]] = 1'b0;
      end
   end

   assign row_1 = w_rows[0];
   assign row_2 = w_rows[1];
   assign row_3 = w_rows[2];
   assign row_4 = w_rows[3];

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_emulator
//  Purpose  : Self-checking bench for keypad_emulator. A timeline model of
//             each accepted command predicts rows/ready/busy/done per cycle;
//             predictions are queued and a monitor compares them on negedge.
//             Honours KEYPAD_EMU_BOUNCE_EN in the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

   localparam int c_G = 4;
   localparam int c_B = 6;

   logic       scan_clk = 1'b0;
   logic       rst_n    = 1'b0;
   logic       col_1 = 1'b1, col_2 = 1'b1, col_3 = 1'b1, col_4 = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_key  = '0;
   logic [7:0] cmd_hold = '0;
   logic       row_1, row_2, row_3, row_4;
   logic       busy, done;

   keypad_emulator #(.HOLD_W(8), .GAP_CYCLES(c_G), .BOUNCE_CYCLES(c_B)) u_dut (
      .scan_clk (scan_clk),
      .rst_n    (rst_n),
      .col_1    (col_1),
      .col_2    (col_2),
      .col_3    (col_3),
      .col_4    (col_4),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_key  (cmd_key),
      .cmd_hold (cmd_hold),
      .row_1    (row_1),
      .row_2    (row_2),
      .row_3    (row_3),
      .row_4    (row_4),
      .busy     (busy),
      .done     (done)
   );

   always #5 scan_clk = ~scan_clk;

   typedef struct {
      logic [3:0] rows;
      logic       ready;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Reference model: a command is a timeline indexed by k = cycles since accept.
   logic       m_active = 1'b0;
   int         m_k, m_h, m_len;
   logic [3:0] m_key;

   function automatic logic m_closed(input int k, input int h);
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (k <= c_B)             return ((k - 1) % 2) == 0;
      if (k <= c_B + h)         return 1'b1;
      if (k <= 2 * c_B + h)     return ((k - c_B - h - 1) % 2) == 1;
      return 1'b0;
`else
      return k <= h;
`endif
   endfunction

   task automatic model_edge(input logic v, input logic [3:0] k, input logic [7:0] h);
      logic was_ready;
      if (rst_n) begin
         was_ready = !m_active || (m_k > m_len);
         if (m_active) m_k++;
         if (v && was_ready) begin
            m_active = 1'b1;
            m_k      = 1;
            m_key    = k;
            m_h      = (h == 0) ? 1 : int'(h);
`ifdef KEYPAD_EMU_BOUNCE_EN
            m_len    = m_h + c_G + 2 * c_B;
`else
            m_len    = m_h + c_G;
`endif
         end
      end
   endtask

   function automatic exp_t model_expect(input logic [3:0] cols);
      exp_t e;
      logic inflight;
      inflight = m_active && (m_k <= m_len);
      e.ready  = !inflight;
      e.busy   = inflight;
      e.done   = m_active && (m_k == m_len + 1);
      e.rows   = 4'hF;
      if (inflight && m_closed(m_k, m_h) && !cols[m_key[1:0]])
         e.rows[m_key[3:2]] = 1'b0;
      return e;
   endfunction

   // One cycle: present command for the coming edge, then set this cycle's
   // columns/reset and queue the prediction for the monitor.
   task automatic step(input logic v, input logic [3:0] k, input logic [7:0] h,
                       input logic [3:0] cols, input logic rst_v);
      cmd_valid = v;
      cmd_key   = k;
      cmd_hold  = h;
      @(posedge scan_clk);
      model_edge(v, k, h);
      #1;
      rst_n = rst_v;
      if (!rst_v) m_active = 1'b0;
      {col_4, col_3, col_2, col_1} = cols;
      exp_q.push_back(model_expect(cols));
   endtask

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, want);
      end
   endtask

   // Monitor: decoupled from stimulus, consumes one prediction per cycle.
   always @(negedge scan_clk) begin
      exp_t e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rows",  {row_4, row_3, row_2, row_1}, e.rows);
         check("ready", {3'b0, cmd_ready}, {3'b0, e.ready});
         check("busy",  {3'b0, busy},      {3'b0, e.busy});
         check("done",  {3'b0, done},      {3'b0, e.done});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] rot(input int i);
      logic [3:0] p;
      p = 4'b1110;
      return (p << (i % 4)) | (p >> (4 - (i % 4)));
   endfunction

   initial begin
      // Reset held, then released with columns cycling and no commands.
      for (int i = 0; i < 3; i++)  step(1'b0, 4'd0, 8'd0, rot(i), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 8'd0, rot(i), 1'b1);

      // Single press key 6, hold 10.
      step(1'b1, 4'd6, 8'd10, rot(0), 1'b1);
      for (int i = 1; i < 18; i++) step(1'b0, 4'd0, 8'd0, rot(i), 1'b1);

      // Hold zero behaves as one.
      step(1'b1, 4'd9, 8'd0, 4'b1101, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 4'd0, 8'd0, 4'b1101, 1'b1);

      // Busy rejection: key 15 kept valid, only taken in the done cycle.
      step(1'b1, 4'd6, 8'd10, rot(2), 1'b1);
      for (int i = 1; i < 16; i++) step(1'b1, 4'd15, 8'd3, rot(i), 1'b1);
      for (int i = 0; i < 14; i++) step(1'b0, 4'd0, 8'd0, rot(i + 3), 1'b1);

      // Reset asserted in cycle 3 of a 10-cycle hold.
      step(1'b1, 4'd6, 8'd10, 4'b1011, 1'b1);
      step(1'b0, 4'd0, 8'd0, 4'b1011, 1'b1);
      step(1'b0, 4'd0, 8'd0, 4'b1011, 1'b0);
      step(1'b0, 4'd0, 8'd0, 4'b1011, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 8'd0, 4'b1011, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)),
              8'($urandom_range(0, 12)),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 299) != 0));
      end

      // Drain the scoreboard.
      cmd_valid = 1'b0;
      @(posedge scan_clk);
      @(negedge scan_clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d queued expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
